// File: rtl/pipeline_foreground_fetch_pkg.sv
// pipeline_foreground_fetch_pkg: shared pipeline definitions.
// Holds the delay-line tag encoding, the default RGB565 chroma key,
// the default pixel word width and the miss-counter saturating helper.
package pipeline_foreground_fetch_pkg;

    localparam int unsigned DEFAULT_COLOR_WIDTH = 16;
    localparam int unsigned TAG_WIDTH           = 2;
    localparam logic [15:0] DEFAULT_CHROMA_KEY  = 16'hF81F;
    localparam logic [15:0] MISS_COUNT_MAX      = 16'hFFFF;

    // Per-slot fate of a read travelling down the latency line.
    typedef enum logic [TAG_WIDTH-1:0] {
        TAG_EMPTY = 2'd0,
        TAG_HIT   = 2'd1,
        TAG_MISS  = 2'd2
    } fetch_tag_t;

    // 16-bit increment that sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == MISS_COUNT_MAX) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/pipeline_latency_delay.sv
// pipeline_latency_delay: WIDTH-bit, DEPTH-stage shift register with
// synchronous active-high reset to all zeros. Advances every cycle.
// Used for the fetch tag line and for aligning data in the blend stage.
module pipeline_latency_delay #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    if (DEPTH < 1) begin : g_bad_depth
        $error("pipeline_latency_delay: DEPTH must be at least 1");
    end

    // Shift one stage per clock; reset flushes every stage to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= data_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign data_o = stage_q[DEPTH-1];

endmodule

// File: rtl/pipeline_foreground_fetch.sv
// pipeline_foreground_fetch: issues one fixed-latency frame-buffer read per
// active foreground coordinate and returns the colour, aligned, to blend.
// Optional feature: define FG_CHROMA_KEY_EN to drop pixels equal to
// CHROMA_KEY (returned as not-valid, not counted as misses).
module pipeline_foreground_fetch
    import pipeline_foreground_fetch_pkg::*;
#(
    parameter int unsigned RESOLUTION_X = 800,
    parameter int unsigned RESOLUTION_Y = 600,
    parameter int unsigned PRECISION    = 11,
    parameter int unsigned ADDR_WIDTH   = 19,
    parameter int unsigned COLOR_WIDTH  = DEFAULT_COLOR_WIDTH,
    parameter int unsigned MEM_LATENCY  = 3
`ifdef FG_CHROMA_KEY_EN
    ,
    parameter logic [COLOR_WIDTH-1:0] CHROMA_KEY = COLOR_WIDTH'(DEFAULT_CHROMA_KEY)
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   output_enable,
    input  logic signed [PRECISION:0] fg_pixel_x,
    input  logic signed [PRECISION:0] fg_pixel_y,
    input  logic                   fg_active,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic                   mem_read_en,
    input  logic                   mem_grant,
    input  logic [COLOR_WIDTH-1:0] mem_data,
    input  logic                   clear_stats,
    output logic [COLOR_WIDTH-1:0] fg_color,
    output logic                   fg_valid,
    output logic [15:0]            miss_count
);

    localparam longint unsigned FRAME_PIXELS = longint'(RESOLUTION_X) * longint'(RESOLUTION_Y);
    localparam int unsigned     PROD_W       = ADDR_WIDTH + PRECISION;

    if (FRAME_PIXELS > (64'd1 << ADDR_WIDTH)) begin : g_addr_too_narrow
        $error("pipeline_foreground_fetch: ADDR_WIDTH cannot cover the frame");
    end

    if (MEM_LATENCY < 1) begin : g_bad_latency
        $error("pipeline_foreground_fetch: MEM_LATENCY must be at least 1");
    end

    // ------------------------------------------------------------------
    // Stage A: address generation and read request
    // ------------------------------------------------------------------
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [PROD_W-1:0]     addr_prod;
    logic                  unused_bits;

    // Sign bits are dropped: fg_active guarantees the coordinate is in frame.
    assign addr_prod = PROD_W'(fg_pixel_y[PRECISION-1:0]) * PROD_W'(RESOLUTION_X)
                     + PROD_W'(fg_pixel_x[PRECISION-1:0]);

    assign unused_bits = ^{addr_prod[PROD_W-1:ADDR_WIDTH],
                           fg_pixel_x[PRECISION], fg_pixel_y[PRECISION]};

    // Request when the pipe advances with a visible pixel; address holds otherwise.
    always_comb begin
        rd_en_d = output_enable && fg_active;
        addr_d  = addr_q;
        if (rd_en_d) begin
            addr_d = addr_prod[ADDR_WIDTH-1:0];
        end
    end

    // Request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            rd_en_q <= rd_en_d;
            addr_q  <= addr_d;
        end
    end

    assign mem_read_en = rd_en_q;
    assign mem_addr    = addr_q;

    // ------------------------------------------------------------------
    // Grant tagging and latency line
    // ------------------------------------------------------------------
    fetch_tag_t             tag_in;
    logic [TAG_WIDTH-1:0]   tag_out_raw;
    fetch_tag_t             tag_out;

    // Classify the slot in the cycle the request is on the bus.
    always_comb begin
        tag_in = TAG_EMPTY;
        if (rd_en_q) begin
            tag_in = mem_grant ? TAG_HIT : TAG_MISS;
        end
    end

    // Tags enter one edge after the request and leave when mem_data is live.
    pipeline_latency_delay #(
        .WIDTH (TAG_WIDTH),
        .DEPTH (MEM_LATENCY)
    ) u_tag_delay (
        .clk    (clk),
        .rst    (rst),
        .data_i (tag_in),
        .data_o (tag_out_raw)
    );

    assign tag_out = fetch_tag_t'(tag_out_raw);

    // ------------------------------------------------------------------
    // Stage B: response capture
    // ------------------------------------------------------------------
    logic                   valid_q, valid_d;
    logic [COLOR_WIDTH-1:0] color_q, color_d;

    // Only a granted slot delivers colour; empty and denied slots emit zero.
    always_comb begin
        valid_d = (tag_out == TAG_HIT);
`ifdef FG_CHROMA_KEY_EN
        if (mem_data == CHROMA_KEY) begin
            valid_d = 1'b0;
        end
`endif
        color_d = valid_d ? mem_data : '0;
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            color_q <= '0;
        end else begin
            valid_q <= valid_d;
            color_q <= color_d;
        end
    end

    assign fg_valid = valid_q;
    assign fg_color = color_q;

    // ------------------------------------------------------------------
    // Denied-read statistics
    // ------------------------------------------------------------------
    logic [15:0] miss_q, miss_d;

    // Clear wins over a same-cycle denial; count sticks at all-ones.
    always_comb begin
        miss_d = miss_q;
        if (clear_stats) begin
            miss_d = '0;
        end else if (rd_en_q && !mem_grant) begin
            miss_d = sat_inc16(miss_q);
        end
    end

    // Miss counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            miss_q <= '0;
        end else begin
            miss_q <= miss_d;
        end
    end

    assign miss_count = miss_q;

endmodule
